// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/flush controller: PCSrc codes and the
// bit ordering of the pipeline enable/bubble-mux control bundle.
package hazard_pkg;

  // PCSrc encodings (3-bit base codes, zero-extended to PCSRC_W)
  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;
  // Any code with bit 2 set is an exception/interrupt vector
  localparam int PCSRC_EXC_BIT = 2;

  // Bit positions inside the control bundle (1 = load / pass)
  localparam int CTL_PCWRITE    = 0;
  localparam int CTL_IFIDWRITE  = 1;
  localparam int CTL_IDEXWRITE  = 2;
  localparam int CTL_EXMEMWRITE = 3;
  localparam int CTL_IFIDMUX    = 4;
  localparam int CTL_IDEXMUX    = 5;
  localparam int CTL_MEMWBMUX   = 6;
  localparam int CTL_N          = 7;

endpackage

// File: rtl/hazard_ctrl_mc_latency_counter.sv
// Load/decrement countdown used to track an outstanding fixed-latency result.
// busy_o is high while the count is nonzero; a load always reloads LAT.
module latency_counter #(
  parameter int LAT = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  output logic [W-1:0] cnt_o,
  output logic         busy_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload takes precedence over the countdown
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = W'(LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard and flush controller for the 5-stage MIPS core.
// Drives pipeline register enables and bubble muxes from a prioritised set
// of hazard conditions: memory freeze, HI/LO busy, load-use, branch, jump,
// exception. Also tracks multi-cycle memory and mult/div latency and counts
// PC-stall cycles (saturating).
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int PCSRC_W = 3,
  parameter int MEM_LAT = 1,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemRead_ex,
  input  logic [REG_W-1:0]   Write_register,
  input  logic [REG_W-1:0]   Rs,
  input  logic [REG_W-1:0]   Rt,
  input  logic [PCSRC_W-1:0] PCSrc,
  input  logic [PCSRC_W-1:0] PCSrc_ex,
  input  logic               ALU_out0,
  input  logic               mem_access,
  input  logic               md_start_ex,
  input  logic               md_use_id,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IDEXWrite,
  output logic               EXMEMWrite,
  output logic               IFIDMux,
  output logic               IDEXMux,
  output logic               MEMWBMux,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               md_busy
);

  localparam int MC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int MD_W = $clog2(MD_LAT + 1);

  logic [MC_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [MD_W-1:0]  md_cnt;
  logic             freeze;
  logic             load_use;
  logic             br_taken;
  logic             jump;
  logic             exc;
  logic [CTL_N-1:0] ctl;

  // Hazard conditions decoded from state and pipeline inputs
  assign freeze   = mem_access && (mem_cnt_q != MC_W'(MEM_LAT - 1));
  assign load_use = MemRead_ex && ((Write_register == Rs) || (Write_register == Rt));
  assign br_taken = (PCSrc_ex == PCSRC_W'(PCSRC_BR)) && ALU_out0;
  assign jump     = (PCSrc == PCSRC_W'(PCSRC_J)) || (PCSrc == PCSRC_W'(PCSRC_JR));
  assign exc      = PCSrc[PCSRC_EXC_BIT];

  // Prioritised control bundle; first matching hazard wins, rest stay 1
  always_comb begin
    ctl = '1;
    if (freeze) begin
      ctl[CTL_PCWRITE]    = 1'b0;
      ctl[CTL_IFIDWRITE]  = 1'b0;
      ctl[CTL_IDEXWRITE]  = 1'b0;
      ctl[CTL_EXMEMWRITE] = 1'b0;
      ctl[CTL_MEMWBMUX]   = 1'b0;
    end else if ((md_busy && md_use_id) || load_use) begin
      ctl[CTL_PCWRITE]    = 1'b0;
      ctl[CTL_IFIDWRITE]  = 1'b0;
      ctl[CTL_IDEXMUX]    = 1'b0;
    end else if (br_taken) begin
      ctl[CTL_IFIDWRITE]  = 1'b0;
      ctl[CTL_IFIDMUX]    = 1'b0;
      ctl[CTL_IDEXMUX]    = 1'b0;
    end else if (jump || exc) begin
      ctl[CTL_IFIDWRITE]  = 1'b0;
      ctl[CTL_IFIDMUX]    = 1'b0;
    end
  end

  assign PCWrite    = ctl[CTL_PCWRITE];
  assign IFIDWrite  = ctl[CTL_IFIDWRITE];
  assign IDEXWrite  = ctl[CTL_IDEXWRITE];
  assign EXMEMWrite = ctl[CTL_EXMEMWRITE];
  assign IFIDMux    = ctl[CTL_IFIDMUX];
  assign IDEXMux    = ctl[CTL_IDEXMUX];
  assign MEMWBMux   = ctl[CTL_MEMWBMUX];

  // Memory-access cycle count advances only while frozen, else returns to 0
  always_comb begin
    mem_cnt_d = '0;
    if (freeze) mem_cnt_d = mem_cnt_q + MC_W'(1);
  end

  // Saturating count of cycles in which the PC was held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_cnt_q   <= mem_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Mult/div result tracker; issue only counts if EX/MEM actually loads
  latency_counter #(
    .LAT (MD_LAT),
    .W   (MD_W)
  ) u_md_cnt (
    .clk    (clk),
    .rst    (reset),
    .load_i (md_start_ex && EXMEMWrite),
    .cnt_o  (md_cnt),
    .busy_o (md_busy)
  );

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed testbench for hazard_ctrl_mc with MEM_LAT=3, MD_LAT=4, CNT_W=4.
// Control outputs are observed as a bundle {PCWrite, IFIDWrite, IDEXWrite,
// EXMEMWrite, IFIDMux, IDEXMux, MEMWBMux}.
module tb_hazard_ctrl_mc;

  localparam int REG_W   = 5;
  localparam int PCSRC_W = 3;
  localparam int MEM_LAT = 3;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;

  localparam logic [6:0] ALL1   = 7'b1111111;
  localparam logic [6:0] FRZ    = 7'b0000110;
  localparam logic [6:0] STALL  = 7'b0011101;
  localparam logic [6:0] BRANCH = 7'b1011001;
  localparam logic [6:0] JUMP   = 7'b1011011;

  logic               clk = 1'b0;
  logic               reset;
  logic               MemRead_ex;
  logic [REG_W-1:0]   Write_register, Rs, Rt;
  logic [PCSRC_W-1:0] PCSrc, PCSrc_ex;
  logic               ALU_out0, mem_access, md_start_ex, md_use_id;
  logic               PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic               IFIDMux, IDEXMux, MEMWBMux;
  logic [CNT_W-1:0]   stall_cnt;
  logic               md_busy;
  logic [6:0]         ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDMux, IDEXMux, MEMWBMux};

  hazard_ctrl_mc #(
    .REG_W(REG_W), .PCSRC_W(PCSRC_W), .MEM_LAT(MEM_LAT), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .MemRead_ex(MemRead_ex), .Write_register(Write_register),
    .Rs(Rs), .Rt(Rt), .PCSrc(PCSrc), .PCSrc_ex(PCSrc_ex), .ALU_out0(ALU_out0),
    .mem_access(mem_access), .md_start_ex(md_start_ex), .md_use_id(md_use_id),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .IFIDMux(IFIDMux), .IDEXMux(IDEXMux),
    .MEMWBMux(MEMWBMux), .stall_cnt(stall_cnt), .md_busy(md_busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead_ex = 0; Write_register = 0; Rs = 0; Rt = 0;
    PCSrc = 0; PCSrc_ex = 0; ALU_out0 = 0;
    mem_access = 0; md_start_ex = 0; md_use_id = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1;
    #1;
    checks++;
    if (ctl !== ALL1 || stall_cnt !== 4'd0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b stall_cnt=%0d md_busy=%b, required ctl=%b stall_cnt=0 md_busy=0",
               ctl, stall_cnt, md_busy, ALL1);
    end
    reset = 0;
    #1;
  endtask

  task automatic test_freeze();
    do_reset();
    mem_access = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ctl !== FRZ) begin
        errors++;
        $display("FAIL freeze_cycle%0d: ctl=%b, required %b", i, ctl, FRZ);
      end
      step();
    end
    checks++;
    if (ctl !== ALL1) begin
      errors++;
      $display("FAIL freeze_release: ctl=%b, required %b", ctl, ALL1);
    end
    checks++;
    if (stall_cnt !== 4'd2) begin
      errors++;
      $display("FAIL freeze_stall_cnt: got %0d, required 2", stall_cnt);
    end
    step();
    // Next access starts fresh: frozen again
    checks++;
    if (ctl !== FRZ) begin
      errors++;
      $display("FAIL freeze_next_access: ctl=%b, required %b", ctl, FRZ);
    end
    mem_access = 0;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    MemRead_ex = 1; Write_register = 5; Rs = 5; Rt = 0;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++;
      $display("FAIL load_use_rs: ctl=%b, required %b", ctl, STALL);
    end
    Write_register = 6;
    #1;
    checks++;
    if (ctl !== ALL1) begin
      errors++;
      $display("FAIL load_use_nomatch: ctl=%b, required %b", ctl, ALL1);
    end
    Write_register = 7; Rt = 7;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++;
      $display("FAIL load_use_rt: ctl=%b, required %b", ctl, STALL);
    end
    MemRead_ex = 0;
    #1;
    checks++;
    if (ctl !== ALL1) begin
      errors++;
      $display("FAIL load_use_noload: ctl=%b, required %b", ctl, ALL1);
    end
  endtask

  task automatic test_branch_jump();
    logic [2:0] codes [4] = '{3'b010, 3'b011, 3'b100, 3'b111};
    do_reset();
    PCSrc_ex = 3'b001; ALU_out0 = 1; PCSrc = 3'b010;
    #1;
    checks++;
    if (ctl !== BRANCH) begin
      errors++;
      $display("FAIL branch_over_jump: ctl=%b, required %b", ctl, BRANCH);
    end
    ALU_out0 = 0;
    for (int i = 0; i < 4; i++) begin
      PCSrc = codes[i];
      #1;
      checks++;
      if (ctl !== JUMP) begin
        errors++;
        $display("FAIL jump_exc_%b: ctl=%b, required %b", codes[i], ctl, JUMP);
      end
    end
    PCSrc = 3'b000;
    #1;
    checks++;
    if (ctl !== ALL1) begin
      errors++;
      $display("FAIL branch_not_taken: ctl=%b, required %b", ctl, ALL1);
    end
  endtask

  task automatic test_md();
    do_reset();
    md_start_ex = 1;
    #1;
    checks++;
    if (ctl !== ALL1 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_issue: ctl=%b md_busy=%b, required %b md_busy=0", ctl, md_busy, ALL1);
    end
    step();
    md_start_ex = 0; md_use_id = 1;
    #1;
    for (int i = 0; i < MD_LAT; i++) begin
      checks++;
      if (ctl !== STALL || md_busy !== 1'b1) begin
        errors++;
        $display("FAIL md_stall%0d: ctl=%b md_busy=%b, required %b md_busy=1", i, ctl, md_busy, STALL);
      end
      step();
    end
    checks++;
    if (ctl !== ALL1 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_done: ctl=%b md_busy=%b, required %b md_busy=0", ctl, md_busy, ALL1);
    end
    checks++;
    if (stall_cnt !== 4'd4) begin
      errors++;
      $display("FAIL md_stall_cnt: got %0d, required 4", stall_cnt);
    end
    md_use_id = 0;
  endtask

  task automatic test_freeze_load_use();
    do_reset();
    mem_access = 1; MemRead_ex = 1; Write_register = 5; Rs = 5;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ctl !== FRZ) begin
        errors++;
        $display("FAIL frz_lu_cycle%0d: ctl=%b, required %b", i, ctl, FRZ);
      end
      step();
    end
    checks++;
    if (ctl !== STALL) begin
      errors++;
      $display("FAIL frz_lu_after: ctl=%b, required %b", ctl, STALL);
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_stall_sat();
    do_reset();
    MemRead_ex = 1; Write_register = 3; Rs = 3;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (stall_cnt !== 4'd14) begin
      errors++;
      $display("FAIL stall_cnt_14: got %0d, required 14", stall_cnt);
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_cnt_sat: got %0d, required 15", stall_cnt);
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_reset_async();
    do_reset();
    // Reset while mult/div busy and a HI/LO reader is stalled
    md_start_ex = 1;
    step();
    md_start_ex = 0; md_use_id = 1;
    #2;
    reset = 1;
    #1;
    checks++;
    if (ctl !== ALL1 || md_busy !== 1'b0 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_busy: ctl=%b md_busy=%b stall_cnt=%0d, required %b 0 0",
               ctl, md_busy, stall_cnt, ALL1);
    end
    reset = 0;
    md_use_id = 0;
    // Reset while frozen: the access restarts from a zero count
    step();
    mem_access = 1;
    step();
    #2;
    reset = 1;
    #1;
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_freeze_cnt: got %0d, required 0", stall_cnt);
    end
    reset = 0;
    step();
    checks++;
    if (ctl !== FRZ) begin
      errors++;
      $display("FAIL reset_mid_freeze_restart: ctl=%b, required %b", ctl, FRZ);
    end
    step();
    checks++;
    if (ctl !== ALL1) begin
      errors++;
      $display("FAIL reset_mid_freeze_release: ctl=%b, required %b", ctl, ALL1);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_freeze();
    test_load_use();
    test_branch_jump();
    test_md();
    test_freeze_load_use();
    test_stall_sat();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
